rx_phase_sync: RTL
==================

// Module: rx_phase_sync
// PURPOSE
//  Receive-side companion to the PRBS9/BPSK/RC transmit chain. Takes the oversampled RC filter
//  output and the local PRBS9 reference bit, then sweeps every (sampling phase, reference delay)
//  candidate and measures the bit errors for each. It locks on the candidate with the fewest
//  errors and then delivers hard-decision bits plus running BER counts. Replaces the
//  switch-selected offset with automatic acquisition.
// PARAMETERS
//  NB_DATA    8    width of signed input sample
//  OS         4    oversampling factor; sample buffer depth
//  NB_PHASE   2    width of phase index, = clog2(OS)
//  NDLY       8    reference delay-line depth, in symbols
//  NB_DLY     3    width of delay index, = clog2(NDLY)
//  N_EVAL     511  symbols evaluated per candidate (one PRBS9 period)
//  NB_CNT     32   width of the LOCK error and bit counters
//  RELOCK_THR 16   per-window error threshold; used only with RX_PHASE_SYNC_RELOCK_EN
// PORTS
//  clock        in   1          system clock
//  i_reset      in   1          asynchronous, active-low reset
//  i_enable     in   1          RX enable
//  i_valid      in   1          symbol strobe, one cycle in every OS
//  i_sample     in   NB_DATA    signed RC filter output, new sample every clock
//  i_ref        in   1          PRBS9 reference bit, qualified by i_valid
//  i_start      in   1          one-cycle pulse: restart acquisition
//  o_bit        out  1          hard decision (sign bit: neg=1, pos=0)
//  o_bit_valid  out  1          o_bit qualifier
//  o_locked     out  1          high while state is LOCK
//  o_phase      out  NB_PHASE   selected sampling phase
//  o_delay      out  NB_DLY     selected reference delay
//  o_errors     out  NB_CNT     errors counted in LOCK
//  o_bits       out  NB_CNT     bits counted in LOCK
//  o_state      out  2          IDLE=0, SETTLE=1, EVAL=2, LOCK=3
// BEHAVIOUR
//  - Reset, and i_reset low at any time:
//    - all outputs 0; state IDLE
//    - sample buffer and delay line cleared
//    - best_err set to all-ones
//  - Sample buffer: shifts every clock; buf[0] <= i_sample.
//  - Delay line: shifts only on i_valid. Tap 0 is the current i_ref; tap k is i_ref k strobes ago.
//  - Candidate index cand = {dly, phase}; phase is the LSBs. Range 0..OS*NDLY-1.
//  - On i_valid: rx = buf[phase][NB_DATA-1]; err = rx ^ tap[dly].
//  - IDLE: i_enable=1 -> SETTLE with cand=0 and best_err=all-ones.
//  - SETTLE: counts NDLY strobes, then -> EVAL with the error accumulator cleared.
//  - EVAL: accumulates err over N_EVAL strobes. At the last strobe:
//    - if acc < best_err (strict; ties keep the lower index), then best <= cand and best_err <= acc
//    - if cand = OS*NDLY-1 -> LOCK on best; else cand+1 -> SETTLE
//  - LOCK:
//    - phase and dly frozen at best; o_phase and o_delay driven from best
//    - o_bit and o_bit_valid registered one cycle after i_valid (latency 1 clock)
//    - o_bits +1 per strobe and o_errors +err; both saturate at 2^NB_CNT-1
//    - o_bit_valid is 0 in every other state
//  - o_phase and o_delay show the current cand during SETTLE and EVAL.
//  - o_errors and o_bits clear on entry to LOCK and hold their value outside LOCK until the next LOCK.
//  - i_start in any state -> SETTLE, cand=0, best_err=all-ones, o_locked=0.
//  - i_enable=0 in any state -> IDLE on the next clock; o_locked=0.
//  - Priority: i_enable=0 > i_start > normal transition.
//  - Strobe sequence: i_valid gaps are legal and counters advance only on strobes.
//  - Acquisition time: OS*NDLY*(NDLY+N_EVAL) strobes = 16608 with the defaults.
// CONFIGURATION
//  RX_PHASE_SYNC_RELOCK_EN defined:
//   - LOCK also counts errors over consecutive N_EVAL-strobe windows
//   - at a window end, if window errors > RELOCK_THR -> restart as for i_start
//   - adds port o_relocks (out, 8 bits), a saturating relock counter reset to 0
//  Macro undefined:
//   - no window counter and no o_relocks port
//   - LOCK is left only by i_start, i_enable=0 or reset
// TESTING
//  1. i_reset=0 mid-EVAL -> all outputs 0 and o_state=0 at once; release with i_enable=1 -> o_state=1.
//  2. Loopback: correct sign at phase 2, i_ref leads the data by 3 strobes
//     -> LOCK after 16608 strobes, o_phase=2, o_delay=3, o_errors=0, o_bits increments per strobe.
//  3. In LOCK, flip the received sign every 100th symbol -> o_errors=10 when o_bits=1000.
//  4. Two candidates give identical zero errors -> the lower cand index is chosen.
//  5. i_enable=0 during SETTLE -> IDLE next clock; same cycle as i_start -> IDLE wins.
//     Re-enable -> sweep restarts at cand 0.
//  6. RELOCK_EN: after LOCK, shift the channel delay to 5
//     -> within one window errors > 16, o_relocks=1, relock with o_delay=5.

Source files
------------

// File: rtl/rx_phase_sync.sv
// rx_phase_sync: sweeps every (sampling phase, reference delay) candidate against the PRBS9 reference,
// locks on the one with fewest bit errors, then outputs hard bits and BER counts.
// Optional windowed relock monitor with the o_relocks port: define RX_PHASE_SYNC_RELOCK_EN.

module rx_phase_sync #(
  parameter int NB_DATA    = 8,
  parameter int OS         = 4,
  parameter int NB_PHASE   = 2,
  parameter int NDLY       = 8,
  parameter int NB_DLY     = 3,
  parameter int N_EVAL     = 511,
  parameter int NB_CNT     = 32
`ifdef RX_PHASE_SYNC_RELOCK_EN
  ,
  parameter int RELOCK_THR = 16
`endif
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic signed [NB_DATA-1:0]  i_sample,
  input  logic                       i_ref,
  input  logic                       i_start,
  output logic                       o_bit,
  output logic                       o_bit_valid,
  output logic                       o_locked,
  output logic [NB_PHASE-1:0]        o_phase,
  output logic [NB_DLY-1:0]          o_delay,
  output logic [NB_CNT-1:0]          o_errors,
  output logic [NB_CNT-1:0]          o_bits,
  output logic [1:0]                 o_state
`ifdef RX_PHASE_SYNC_RELOCK_EN
  ,
  output logic [7:0]                 o_relocks
`endif
);

  localparam int NCAND   = OS * NDLY;
  localparam int NB_CAND = NB_PHASE + NB_DLY;
  localparam int NB_ACC  = $clog2(N_EVAL + 1) + 1;
  localparam int NB_SCNT = $clog2(N_EVAL + NDLY);

  localparam logic [NB_SCNT-1:0] SETTLE_LAST = NB_SCNT'(NDLY - 1);
  localparam logic [NB_SCNT-1:0] EVAL_LAST   = NB_SCNT'(N_EVAL - 1);
  localparam logic [NB_CAND-1:0] CAND_LAST   = NB_CAND'(NCAND - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EVAL   = 2'd2,
    ST_LOCK   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NB_CAND-1:0]  cand_q, cand_d;
  logic [NB_CAND-1:0]  best_q, best_d;
  logic [NB_ACC-1:0]   best_err_q, best_err_d;
  logic [NB_ACC-1:0]   acc_q, acc_d;
  logic [NB_SCNT-1:0]  cnt_q, cnt_d;
  logic [OS-1:0]       sbuf_q, sbuf_d;
  logic [NDLY-2:0]     dline_q, dline_d;
  logic                bit_q, bit_d;
  logic                bit_valid_q, bit_valid_d;
  logic [NB_CNT-1:0]   errors_q, errors_d;
  logic [NB_CNT-1:0]   bits_q, bits_d;

  logic [NDLY-1:0]     tap;
  logic [NB_PHASE-1:0] sel_phase;
  logic [NB_DLY-1:0]   sel_dly;
  logic                rx;
  logic                err;
  logic                restart;
  logic [NB_ACC-1:0]   acc_sum;

  // Only the sign of each sample is ever examined, so the buffer holds sign bits.
  logic unused_mag;
  assign unused_mag = ^i_sample[NB_DATA-2:0];

  assign tap       = {dline_q, i_ref};
  assign sel_phase = (state_q == ST_LOCK) ? best_q[NB_PHASE-1:0] : cand_q[NB_PHASE-1:0];
  assign sel_dly   = (state_q == ST_LOCK) ? best_q[NB_CAND-1:NB_PHASE] : cand_q[NB_CAND-1:NB_PHASE];
  assign rx        = sbuf_q[sel_phase];
  assign err       = rx ^ tap[sel_dly];
  assign acc_sum   = acc_q + {{(NB_ACC-1){1'b0}}, err};

`ifdef RX_PHASE_SYNC_RELOCK_EN
  localparam logic [NB_ACC-1:0] RELOCK_LIM = NB_ACC'(RELOCK_THR);

  logic [NB_SCNT-1:0] win_cnt_q, win_cnt_d;
  logic [NB_ACC-1:0]  win_err_q, win_err_d;
  logic [7:0]         relocks_q, relocks_d;
  logic [NB_ACC-1:0]  win_sum;
  logic               relock_hit;

  assign win_sum    = win_err_q + {{(NB_ACC-1){1'b0}}, err};
  assign relock_hit = (state_q == ST_LOCK) && i_valid && (win_cnt_q == EVAL_LAST) && (win_sum > RELOCK_LIM);
  assign restart    = i_start || relock_hit;
  assign o_relocks  = relocks_q;
`else
  assign restart    = i_start;
`endif

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    best_d      = best_q;
    best_err_d  = best_err_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    errors_d    = errors_q;
    bits_d      = bits_q;
    sbuf_d      = {sbuf_q[OS-2:0], i_sample[NB_DATA-1]};
    dline_d     = i_valid ? {dline_q[NDLY-3:0], i_ref} : dline_q;
`ifdef RX_PHASE_SYNC_RELOCK_EN
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    relocks_d   = relocks_q;
    if (i_enable && relock_hit && (relocks_q != 8'hFF)) begin
      relocks_d = relocks_q + 8'd1;
    end
`endif

    if (!i_enable) begin
      state_d = ST_IDLE;
      cand_d  = '0;
      cnt_d   = '0;
    end else if (restart || (state_q == ST_IDLE)) begin
      state_d    = ST_SETTLE;
      cand_d     = '0;
      best_err_d = '1;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          // The settle period refills the delay line for the new candidate.
          if (i_valid) begin
            if (cnt_q == SETTLE_LAST) begin
              state_d = ST_EVAL;
              cnt_d   = '0;
              acc_d   = '0;
            end else begin
              cnt_d = cnt_q + NB_SCNT'(1);
            end
          end
        end
        ST_EVAL: begin
          if (i_valid) begin
            if (cnt_q == EVAL_LAST) begin
              cnt_d = '0;
              if (acc_sum < best_err_q) begin
                best_d     = cand_q;
                best_err_d = acc_sum;
              end
              if (cand_q == CAND_LAST) begin
                state_d  = ST_LOCK;
                errors_d = '0;
                bits_d   = '0;
`ifdef RX_PHASE_SYNC_RELOCK_EN
                win_cnt_d = '0;
                win_err_d = '0;
`endif
              end else begin
                cand_d  = cand_q + NB_CAND'(1);
                state_d = ST_SETTLE;
              end
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + NB_SCNT'(1);
            end
          end
        end
        ST_LOCK: begin
          if (i_valid) begin
            bit_d       = rx;
            bit_valid_d = 1'b1;
            if (bits_q != '1) begin
              bits_d = bits_q + NB_CNT'(1);
            end
            if (err && (errors_q != '1)) begin
              errors_d = errors_q + NB_CNT'(1);
            end
`ifdef RX_PHASE_SYNC_RELOCK_EN
            if (win_cnt_q == EVAL_LAST) begin
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + NB_SCNT'(1);
              win_err_d = win_sum;
            end
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      best_q      <= '0;
      best_err_q  <= '1;
      acc_q       <= '0;
      cnt_q       <= '0;
      sbuf_q      <= '0;
      dline_q     <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      errors_q    <= '0;
      bits_q      <= '0;
`ifdef RX_PHASE_SYNC_RELOCK_EN
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      relocks_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      best_q      <= best_d;
      best_err_q  <= best_err_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sbuf_q      <= sbuf_d;
      dline_q     <= dline_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      errors_q    <= errors_d;
      bits_q      <= bits_d;
`ifdef RX_PHASE_SYNC_RELOCK_EN
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      relocks_q   <= relocks_d;
`endif
    end
  end

  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_locked    = (state_q == ST_LOCK);
  assign o_phase     = sel_phase;
  assign o_delay     = sel_dly;
  assign o_errors    = errors_q;
  assign o_bits      = bits_q;
  assign o_state     = state_q;

endmodule
